tc_bank: RTL and testbench
==========================

# tc_bank

Parametrised timer/counter bank that replaces the fixed four-timer/four-counter peripheral set with one block of NUM_CH identical channels. Each channel is run-time configurable as an on-delay, off-delay or retentive timer, or as an up/down event counter. A shared prescaler derives the timer timebase, and a per-channel interrupt flag signals done-bit rising edges. It sits in the execute stage beside the bit/byte RAMs: control-unit strobes and instruction-field selects drive it, and the accumulator supplies write data and captures read data.

## Interface
Parameters:
- NUM_CH, 8: number of channels (2..16).
- ACC_W, 8: accumulator/preset width (8..16).
- TICK_DIV, 1000: clk cycles per timebase tick (≥2).
- CH_W, 4: channel-select width, ≥ ceil(log2(NUM_CH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- wr_en  in  1  one-cycle write strobe.
- wr_reg  in  2  write target: 0 ctrl, 1 preset, 2 clear, 3 irq ack.
- ch_sel  in  CH_W  channel addressed by both write and read; values ≥ NUM_CH make writes ignored and reads return 0.
- wr_data  in  ACC_W  write data from the accumulator.
- rd_reg  in  1  read target: 0 acc, 1 status.
- rd_data  out  ACC_W  combinational read of the selected register.
- cnt_in  in  NUM_CH  asynchronous count inputs, one per channel.
- dn  out  NUM_CH  done bits, registered.
- tt  out  NUM_CH  timing bits, registered.
- irq  out  1  OR of all irq_pend bits, registered.

## Operation
- Ctrl byte (wr_data[7:0]): [0] en, [2:1] mode (00 TON, 01 TOF, 10 RTO, 11 CNT), [3] dir (0 up, 1 down; CNT only), [4] ie.
- Status read: [0] en, [2:1] mode, [3] dir, [4] ie, [5] tt, [6] dn, [7] irq_pend. Bits above 7 read 0.
- Prescaler: a single counter runs 0..TICK_DIV-1. tick pulses for one cycle on wrap. The first tick after reset occurs at cycle TICK_DIV.
- TON (non-retentive on-delay):
  - While en=1 and !dn, acc increments on each tick. dn sets when acc ≥ preset. acc saturates at preset.
  - tt = en & !dn.
  - en=0 clears acc, dn and tt.
- TOF (off-delay):
  - en=1 forces dn=1, acc=0, tt=0.
  - After an en 1→0 transition with dn=1, acc increments per tick and tt=1. When acc ≥ preset, dn and tt clear and acc holds.
  - en reasserted mid-timing returns to dn=1, acc=0.
- RTO (retentive on-delay): as TON, except en=0 holds acc and dn. Only a clear write zeroes them.
- CNT (counter), counting on rising edges of the synchronised cnt_in while en=1:
  - Up: acc+1, saturating at 2^ACC_W−1. dn = acc ≥ preset.
  - Down: acc−1, saturating at 0. dn = (acc==0).
  - tt is always 0.
- Clear write: acc loads preset if in CNT down, otherwise 0. dn and tt are recomputed from the new acc.
- Ctrl write: if mode or dir changes, acc, dn and tt clear (CNT down loads preset).
- Preset write: the new preset is used for comparison from the next cycle. preset=0 gives TON/RTO dn=1 one cycle after en.
- irq_pend[ch]:
  - Sets on a dn 0→1 transition when ie=1.
  - Clears on an ack write to that channel. If set and ack coincide, set wins.
  - Writing ie=0 does not clear a pending flag.
- Priority within a channel per cycle: clear > ctrl write > tick/count event.

## Timing
- All writes take effect at the clk edge on which wr_en is high.
- acc, dn and tt update on the same edge. dn/tt are computed from next-state acc, so they never lag acc.
- cnt_in path: two-flop synchroniser plus edge detect. acc changes on the 3rd rising clk edge at which cnt_in is sampled high. Input pulses must be high and low for ≥2 clk each.
- irq asserts one cycle after the dn rising edge.
- Reset values: all outputs 0. prescaler=0, all acc=0, preset=0, ctrl=0 (en=0, TON), irq_pend=0, synchroniser flops=0.
- Reset asserted mid-operation aborts timing immediately, with no glitch on dn/tt beyond the asynchronous clear.

## Test plan
- TICK_DIV=4, ch0 TON preset=3, en=1 at cycle 10 → tt=1 from cycle 11. dn=1 on the 3rd tick (acc=3) and acc holds at 3. en=0 → acc=0, dn=0 next cycle.
- ch1 RTO preset=5: enable for 2 ticks, disable 10 ticks, enable 3 ticks → acc holds 2 while disabled, then dn=1 at acc=5. en=0 keeps dn=1 until a clear write → acc=0, dn=0.
- ch2 TOF preset=2: en 1→0 → tt=1 and dn=1 for 2 ticks, then dn=0. Re-enable at acc=1 → acc=0, dn=1, tt=0.
- ch3 CNT up preset=2, ie=1: three cnt_in pulses → acc=3, dn=1 from acc=2. irq=1 one cycle later. Ack write → irq=0. Ack coinciding with a new dn rise → irq stays 1.
- ch4 CNT down preset=1: clear → acc=1. Two pulses → acc=0 (saturates), dn=1. ACC_W=8 up count from 255 stays at 255.
- Corners: clear and count edge in the same cycle → acc=0. ch_sel=NUM_CH write → no state change, read = 0. Reset pulse mid-count → all outputs 0 asynchronously.

Source files
------------

// File: rtl/tc_bank.sv
// rtl/tc_bank.sv - timer/counter bank: NUM_CH configurable TON/TOF/RTO/CNT channels
//
// Purpose:
//   Bank of identical channels sharing one prescaler. Each channel is an
//   on-delay, off-delay or retentive timer, or an up/down event counter,
//   selected by its ctrl register. A per-channel interrupt flag latches
//   done-bit rising edges when enabled.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset, clears all state
//   wr_en    - one-cycle write strobe
//   wr_reg   - write target: 0 ctrl, 1 preset, 2 clear, 3 irq ack
//   ch_sel   - channel for write and read; out-of-range ignores writes, reads 0
//   wr_data  - write data (ctrl uses bits [4:0])
//   rd_reg   - read target: 0 acc, 1 status
//   rd_data  - combinational read of the selected register
//   cnt_in   - asynchronous count inputs, one per channel
//   dn       - registered done bits
//   tt       - registered timing bits
//   irq      - registered OR of all pending interrupt flags
module tc_bank #(
  parameter int NUM_CH   = 8,
  parameter int ACC_W    = 8,
  parameter int TICK_DIV = 1000,
  parameter int CH_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_reg,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [ACC_W-1:0]  wr_data,
  input  logic              rd_reg,
  output logic [ACC_W-1:0]  rd_data,
  input  logic [NUM_CH-1:0] cnt_in,
  output logic [NUM_CH-1:0] dn,
  output logic [NUM_CH-1:0] tt,
  output logic              irq
);

  typedef enum logic [1:0] {
    MODE_TON = 2'b00,
    MODE_TOF = 2'b01,
    MODE_RTO = 2'b10,
    MODE_CNT = 2'b11
  } mode_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;
  localparam logic [1:0] REG_ACK    = 2'd3;

  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
  localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);

  // Shared prescaler; tick is high during the cycle whose edge wraps it.
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tick;

  assign tick  = (psc_q == PSC_LAST);
  assign psc_d = tick ? '0 : psc_q + PSC_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  // Channel behaviour for one cycle. Returns {acc, dn, tt}.
  // hold_dn keeps TON/RTO done unchanged on a ctrl-write cycle so that the
  // preset comparison only starts the cycle after enable.
  function automatic logic [ACC_W+1:0] chan_eval(
    input logic             en,
    input mode_e            mode,
    input logic             dir,
    input logic [ACC_W-1:0] acc,
    input logic             dn_in,
    input logic [ACC_W-1:0] pre,
    input logic             tick_ev,
    input logic             cnt_ev,
    input logic             hold_dn
  );
    logic [ACC_W-1:0] a;
    logic             d;
    logic             t;
    a = acc;
    d = dn_in;
    t = 1'b0;
    case (mode)
      MODE_TON, MODE_RTO: begin
        if (!en) begin
          // TON drops everything when disabled; RTO retains
          if (mode == MODE_TON) begin
            a = '0;
            d = 1'b0;
          end
        end else begin
          if (tick_ev && !dn_in && (acc != ACC_MAX)) begin
            a = acc + ACC_ONE;
          end
          if (!hold_dn) begin
            d = (a >= pre);
          end
        end
        t = en & ~d;
      end
      MODE_TOF: begin
        if (en) begin
          a = '0;
          d = 1'b1;
        end else if (dn_in) begin
          // off-delay running: done stays high until acc reaches preset
          if (tick_ev && (acc != ACC_MAX)) begin
            a = acc + ACC_ONE;
          end
          d = (a < pre);
        end
        t = ~en & d;
      end
      default: begin
        if (en && cnt_ev) begin
          if (dir) begin
            if (acc != '0) begin
              a = acc - ACC_ONE;
            end
          end else if (acc != ACC_MAX) begin
            a = acc + ACC_ONE;
          end
        end
        d = dir ? (a == '0) : (a >= pre);
        t = 1'b0;
      end
    endcase
    return {a, d, t};
  endfunction

  logic [ACC_W-1:0] acc_v  [NUM_CH];
  logic [7:0]       stat_v [NUM_CH];
  logic [NUM_CH-1:0] pend_v;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // ctl: [0] en, [2:1] mode, [3] dir, [4] ie
    logic [4:0]       ctl_q, ctl_d;
    logic [ACC_W-1:0] pre_q, pre_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             dn_q, dn_d;
    logic             tt_q, tt_d;
    logic             pend_q, pend_d;
    logic [2:0]       sync_q;

    logic             wr_hit, clr_hit, ctl_hit, pre_hit, ack_hit;
    logic             cnt_ev, mode_chg;
    logic [ACC_W-1:0] base_acc;
    logic [ACC_W+1:0] ev_res;

    assign wr_hit  = wr_en && (ch_sel == CH_W'(gi));
    assign clr_hit = wr_hit && (wr_reg == REG_CLEAR);
    assign ctl_hit = wr_hit && (wr_reg == REG_CTRL);
    assign pre_hit = wr_hit && (wr_reg == REG_PRESET);
    assign ack_hit = wr_hit && (wr_reg == REG_ACK);

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history
    assign cnt_ev   = sync_q[1] & ~sync_q[2];
    assign mode_chg = (wr_data[2:1] != ctl_q[2:1]) || (wr_data[3] != ctl_q[3]);

    assign ctl_d = ctl_hit ? wr_data[4:0] : ctl_q;
    assign pre_d = pre_hit ? wr_data : pre_q;

    always_comb begin
      base_acc = acc_q;
      ev_res   = '0;
      if (clr_hit) begin
        base_acc = ((mode_e'(ctl_q[2:1]) == MODE_CNT) && ctl_q[3]) ? pre_q : '0;
        ev_res   = chan_eval(ctl_q[0], mode_e'(ctl_q[2:1]), ctl_q[3], base_acc,
                             1'b0, pre_q, 1'b0, 1'b0, 1'b0);
      end else if (ctl_hit) begin
        if (mode_chg) begin
          base_acc = ((mode_e'(wr_data[2:1]) == MODE_CNT) && wr_data[3]) ? pre_q : '0;
        end
        ev_res = chan_eval(wr_data[0], mode_e'(wr_data[2:1]), wr_data[3], base_acc,
                           mode_chg ? 1'b0 : dn_q, pre_q, 1'b0, 1'b0, 1'b1);
      end else begin
        ev_res = chan_eval(ctl_q[0], mode_e'(ctl_q[2:1]), ctl_q[3], acc_q,
                           dn_q, pre_q, tick, cnt_ev, 1'b0);
      end
    end

    assign acc_d  = ev_res[ACC_W+1:2];
    assign dn_d   = ev_res[1];
    assign tt_d   = ev_res[0];
    // a new done edge beats a coincident ack
    assign pend_d = (ctl_d[4] & dn_d & ~dn_q) | (pend_q & ~ack_hit);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctl_q  <= '0;
        pre_q  <= '0;
        acc_q  <= '0;
        dn_q   <= 1'b0;
        tt_q   <= 1'b0;
        pend_q <= 1'b0;
        sync_q <= '0;
      end else begin
        ctl_q  <= ctl_d;
        pre_q  <= pre_d;
        acc_q  <= acc_d;
        dn_q   <= dn_d;
        tt_q   <= tt_d;
        pend_q <= pend_d;
        sync_q <= {sync_q[1:0], cnt_in[gi]};
      end
    end

    assign dn[gi]     = dn_q;
    assign tt[gi]     = tt_q;
    assign pend_v[gi] = pend_q;
    assign acc_v[gi]  = acc_q;
    assign stat_v[gi] = {pend_q, dn_q, tt_q, ctl_q};
  end

  logic irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pend_v;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        rd_data = rd_reg ? ACC_W'(stat_v[i]) : acc_v[i];
      end
    end
  end

endmodule

// File: tb/tb_tc_bank.sv
// tb/tb_tc_bank.sv - scoreboard bench for tc_bank against a behavioural model
module tb_tc_bank;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int TD = 4;
  localparam int CW = 4;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [1:0]    wr_reg  = '0;
  logic [CW-1:0] ch_sel  = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_reg  = 1'b0;
  logic [N-1:0]  cnt_in  = '0;
  logic [W-1:0]  rd_data;
  logic [N-1:0]  dn;
  logic [N-1:0]  tt;
  logic          irq;

  tc_bank #(.NUM_CH(N), .ACC_W(W), .TICK_DIV(TD), .CH_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_reg(wr_reg), .ch_sel(ch_sel),
    .wr_data(wr_data), .rd_reg(rd_reg), .rd_data(rd_data), .cnt_in(cnt_in),
    .dn(dn), .tt(tt), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] dn;
    logic [N-1:0] tt;
    logic         irq;
    logic [W-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  bit       m_en[N], m_dir[N], m_ie[N], m_dn[N], m_pend[N];
  bit [1:0] m_mode[N];
  int       m_acc[N], m_pre[N];
  bit       h1[N], h2[N], h3[N];   // cnt_in sampled 1, 2, 3 edges ago
  int       cyc;
  bit       m_irq;

  function automatic bit tt_of(int c);
    case (m_mode[c])
      2'd0, 2'd2: return m_en[c] && !m_dn[c];
      2'd1:       return !m_en[c] && m_dn[c];
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit cnt_done(int c);
    return m_dir[c] ? (m_acc[c] == 0) : (m_acc[c] >= m_pre[c]);
  endfunction

  function automatic int up1(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_step();
    bit tick, ev, hit, old_dn, irq_n;
    bit [1:0] nm;
    bit nd;
    if (!reset) begin
      for (int c = 0; c < N; c++) begin
        m_en[c] = 0; m_dir[c] = 0; m_ie[c] = 0; m_dn[c] = 0; m_pend[c] = 0;
        m_mode[c] = 0; m_acc[c] = 0; m_pre[c] = 0; h1[c] = 0; h2[c] = 0; h3[c] = 0;
      end
      cyc = 0;
      m_irq = 0;
      return;
    end
    cyc++;
    tick = ((cyc % TD) == 0);
    irq_n = 0;
    for (int c = 0; c < N; c++) irq_n |= m_pend[c];
    for (int c = 0; c < N; c++) begin
      hit = wr_en && (int'(ch_sel) == c);
      ev = h2[c] && !h3[c];
      h3[c] = h2[c]; h2[c] = h1[c]; h1[c] = cnt_in[c];
      old_dn = m_dn[c];
      if (hit && wr_reg == 2'd2) begin
        m_acc[c] = (m_mode[c] == 3 && m_dir[c]) ? m_pre[c] : 0;
        case (m_mode[c])
          2'd0, 2'd2: m_dn[c] = m_en[c] && (m_acc[c] >= m_pre[c]);
          2'd1:       m_dn[c] = m_en[c];
          default:    m_dn[c] = cnt_done(c);
        endcase
      end else if (hit && wr_reg == 2'd0) begin
        nm = wr_data[2:1];
        nd = wr_data[3];
        if (nm != m_mode[c] || nd != m_dir[c]) begin
          m_acc[c] = (nm == 3 && nd) ? m_pre[c] : 0;
          m_dn[c] = 0;
        end
        m_en[c] = wr_data[0]; m_mode[c] = nm; m_dir[c] = nd; m_ie[c] = wr_data[4];
        case (m_mode[c])
          2'd0: if (!m_en[c]) begin m_acc[c] = 0; m_dn[c] = 0; end
          2'd2: ;
          2'd1: begin
            if (m_en[c]) begin m_acc[c] = 0; m_dn[c] = 1; end
            else if (m_dn[c] && m_acc[c] >= m_pre[c]) m_dn[c] = 0;
          end
          default: m_dn[c] = cnt_done(c);
        endcase
      end else begin
        case (m_mode[c])
          2'd0, 2'd2: begin
            if (m_en[c]) begin
              if (tick && !m_dn[c]) m_acc[c] = up1(m_acc[c]);
              m_dn[c] = (m_acc[c] >= m_pre[c]);
            end else if (m_mode[c] == 2'd0) begin
              m_acc[c] = 0; m_dn[c] = 0;
            end
          end
          2'd1: begin
            if (m_en[c]) begin m_acc[c] = 0; m_dn[c] = 1; end
            else if (m_dn[c]) begin
              if (tick) m_acc[c] = up1(m_acc[c]);
              if (m_acc[c] >= m_pre[c]) m_dn[c] = 0;
            end
          end
          default: begin
            if (m_en[c] && ev)
              m_acc[c] = m_dir[c] ? ((m_acc[c] > 0) ? m_acc[c] - 1 : 0) : up1(m_acc[c]);
            m_dn[c] = cnt_done(c);
          end
        endcase
      end
      if (hit && wr_reg == 2'd1) m_pre[c] = int'(wr_data);
      m_pend[c] = (m_ie[c] && m_dn[c] && !old_dn) || (m_pend[c] && !(hit && wr_reg == 2'd3));
    end
    m_irq = irq_n;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    int c;
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.dn[i] = m_dn[i];
      e.tt[i] = tt_of(i);
    end
    e.irq = m_irq;
    c = int'(ch_sel);
    if (c < N)
      e.rd = rd_reg ? {m_pend[c], m_dn[c], tt_of(c), m_ie[c], m_dir[c], m_mode[c], m_en[c]}
                    : W'(m_acc[c]);
    return e;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] ex);
    vectors++;
    if (act !== ex) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  // monitor: async reset check on reset fall, otherwise pop one expectation per edge
  initial begin
    exp_t e;
    bit prev_rst;
    prev_rst = 1'b0;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (prev_rst && !reset) begin
        cmp("async_rst_dn", 32'(dn), 32'd0);
        cmp("async_rst_tt", 32'(tt), 32'd0);
        cmp("async_rst_irq", 32'(irq), 32'd0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("dn", 32'(dn), 32'(e.dn));
        cmp("tt", 32'(tt), 32'(e.tt));
        cmp("irq", 32'(irq), 32'(e.irq));
        cmp("rd_data", 32'(rd_data), 32'(e.rd));
      end
      prev_rst = reset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    model_step();
    exp_q.push_back(make_exp());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      ch_sel = CW'($urandom_range(0, N));
      rd_reg = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic wr(int r, int c, int d);
    wr_en = 1'b1;
    wr_reg = r[1:0];
    ch_sel = c[CW-1:0];
    wr_data = d[W-1:0];
    rd_reg = 1'($urandom_range(0, 1));
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse(int c);
    cnt_in[c] = 1'b1;
    idle(2);
    cnt_in[c] = 1'b0;
    idle(2);
  endtask

  initial begin
    @(negedge clk);
    idle(3);
    reset = 1'b1;
    idle(6);
    // ch0 TON preset 3
    wr(1, 0, 3);
    wr(0, 0, 8'h01);
    idle(20);
    wr(0, 0, 8'h00);
    idle(3);
    // ch1 RTO preset 5
    wr(1, 1, 5);
    wr(0, 1, 8'h05);
    idle(8);
    wr(0, 1, 8'h04);
    idle(40);
    wr(0, 1, 8'h05);
    idle(16);
    wr(0, 1, 8'h04);
    idle(4);
    wr(2, 1, 0);
    idle(2);
    // ch2 TOF preset 2
    wr(1, 2, 2);
    wr(0, 2, 8'h03);
    idle(3);
    wr(0, 2, 8'h02);
    idle(5);
    wr(0, 2, 8'h03);
    idle(2);
    wr(0, 2, 8'h02);
    idle(12);
    // ch3 CNT up preset 2 with interrupts
    wr(1, 3, 2);
    wr(0, 3, 8'h17);
    repeat (3) pulse(3);
    idle(3);
    wr(3, 3, 0);
    idle(3);
    wr(2, 3, 0);
    pulse(3);
    cnt_in[3] = 1'b1;
    idle(2);
    cnt_in[3] = 1'b0;
    wr(3, 3, 0);          // ack on the same edge as the new done rise
    idle(3);
    cnt_in[3] = 1'b1;
    idle(2);
    cnt_in[3] = 1'b0;
    wr(2, 3, 0);          // clear on the same edge as a count event
    idle(2);
    // ch4 CNT down preset 1
    wr(1, 4, 1);
    wr(0, 4, 8'h0F);
    wr(2, 4, 0);
    pulse(4);
    pulse(4);
    // ch5 CNT up saturation
    wr(0, 5, 8'h07);
    repeat (257) pulse(5);
    // out-of-range channel
    wr(0, N, 8'h1F);
    wr(1, N, 8'hAA);
    wr(2, N, 0);
    wr(3, N, 0);
    idle(4);
    // randomized traffic
    repeat (400) begin
      cnt_in = N'($urandom);
      if ($urandom_range(0, 3) == 0)
        wr(int'($urandom_range(0, 3)), int'($urandom_range(0, N)), int'($urandom_range(0, 255)));
      else
        idle(1);
    end
    // reset pulse mid-count
    cnt_in = '0;
    wr(0, 6, 8'h03);
    idle(2);
    cnt_in[5] = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    cnt_in = '0;
    idle(4);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
